// File: rtl/image_stream_feeder.sv
// Buffers one IMG_W x IMG_H 8-bit frame from a ready/valid host stream, replays it as a gapless burst
// one cycle after the last pixel lands, then reports the classifier result or a timeout; host_ready is high only in LOAD.
module image_stream_feeder #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int TIMEOUT = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        host_valid,
  input  logic [7:0]  host_data,
  output logic        host_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        class_valid,
  input  logic [3:0]  class_out,
  output logic        res_valid,
  output logic [3:0]  res_class,
  output logic        res_timeout,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int N  = IMG_W * IMG_H;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_PIX = CW'(N - 1);
  localparam logic [TW-1:0] LAST_TMO = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD, STREAM, WAIT} state_t;

  state_t        state, state_nxt;
  logic [7:0]    pix_buf [N];
  logic [CW-1:0] wr_cnt, rd_cnt, rd_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          accept, load_done, stream_last, res_fire, res_tmo;

  assign rd_nxt = rd_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // flush overrides every state and also blocks the host handshake in its own cycle
  always_comb begin
    state_nxt   = state;
    host_ready  = 1'b0;
    accept      = 1'b0;
    load_done   = 1'b0;
    stream_last = 1'b0;
    res_fire    = 1'b0;
    res_tmo     = 1'b0;
    if (flush) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD: begin
          host_ready = 1'b1;
          accept     = host_valid;
          if (host_valid && wr_cnt == LAST_PIX) begin
            load_done = 1'b1;
            state_nxt = STREAM;
          end
        end
        STREAM: begin
          if (rd_cnt == LAST_PIX) begin
            stream_last = 1'b1;
            state_nxt   = WAIT;
          end
        end
        WAIT: begin
          if (class_valid) begin
            res_fire  = 1'b1;
            state_nxt = LOAD;
          end else if (tmo_cnt == LAST_TMO) begin
            res_fire  = 1'b1;
            res_tmo   = 1'b1;
            state_nxt = LOAD;
          end
        end
        default: state_nxt = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pix_buf[wr_cnt] <= host_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      tmo_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      if (flush)       wr_cnt <= '0;
      else if (accept) wr_cnt <= load_done ? '0 : wr_cnt + 1'b1;

      rd_cnt    <= (state == STREAM && state_nxt == STREAM) ? rd_nxt : '0;
      tmo_cnt   <= (state == WAIT && state_nxt == WAIT) ? tmo_cnt + 1'b1 : '0;
      out_valid <= (state_nxt == STREAM);
      // busy stays up through the result cycle so the host sees one continuous busy window
      busy      <= (state_nxt != LOAD) || res_fire;

      // a single-pixel frame has its only pixel arriving on the load edge itself
      if (load_done)
        out_data <= (wr_cnt == '0) ? host_data : pix_buf[0];
      else if (state == STREAM && !stream_last && !flush)
        out_data <= pix_buf[rd_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid   <= 1'b0;
      res_class   <= 4'h0;
      res_timeout <= 1'b0;
      frame_cnt   <= 16'h0000;
    end else begin
      res_valid <= res_fire;
      if (res_fire) begin
        res_class   <= res_tmo ? 4'hF : class_out;
        res_timeout <= res_tmo;
        frame_cnt   <= frame_cnt + 16'd1;
      end
    end
  end

endmodule
